ysyx_rs_age: RTL and testbench

- Parametrised reservation station that replaces the fixed lowest-index-first RS inside the execute unit.
- Selection is oldest-ready-first, via an age matrix.
- Supports NWB parallel writeback/wakeup ports (CDB) and an opaque per-entry payload, so one RS RTL serves the ALU, MUL and LSU queues.
- Sits between dispatch (IDU) and one functional unit; the FU's result returns on a writeback port.

---
 rtl/ysyx_rs_age.sv | 168 ++++++++++++++++
 tb/tb_ysyx_rs_age.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_rs_age.sv
// Reservation station with oldest-ready-first selection through an age matrix,
// NWB wakeup ports with dispatch bypass, and an opaque per-entry payload.
`ifndef YSYX_XLEN
`define YSYX_XLEN 64
`endif
`ifndef YSYX_ROB_SIZE
`define YSYX_ROB_SIZE 16
`endif

module ysyx_rs_age #(
  parameter int DEPTH     = 4,
  parameter int NWB       = 2,
  parameter int XLEN      = `YSYX_XLEN,
  parameter int TAG_W     = $clog2(`YSYX_ROB_SIZE) + 1,
  parameter int PAYLOAD_W = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [TAG_W-1:0]           disp_qj,
  input  logic [TAG_W-1:0]           disp_qk,
  input  logic [XLEN-1:0]            disp_vj,
  input  logic [XLEN-1:0]            disp_vk,
  input  logic [TAG_W-1:0]           disp_dest,
  input  logic [PAYLOAD_W-1:0]       disp_payload,
  input  logic [NWB-1:0]             wb_valid,
  input  logic [NWB*TAG_W-1:0]       wb_tag,
  input  logic [NWB*XLEN-1:0]        wb_data,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic [XLEN-1:0]            iss_vj,
  output logic [XLEN-1:0]            iss_vk,
  output logic [TAG_W-1:0]           iss_dest,
  output logic [PAYLOAD_W-1:0]       iss_payload,
  output logic [$clog2(DEPTH)-1:0]   iss_idx,
  output logic [$clog2(DEPTH):0]     occupancy
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = IDX_W + 1;

  logic [DEPTH-1:0]     busy_r;
  logic [TAG_W-1:0]     qj_r      [DEPTH];
  logic [TAG_W-1:0]     qk_r      [DEPTH];
  logic [XLEN-1:0]      vj_r      [DEPTH];
  logic [XLEN-1:0]      vk_r      [DEPTH];
  logic [TAG_W-1:0]     dest_r    [DEPTH];
  logic [PAYLOAD_W-1:0] payload_r [DEPTH];
  logic [DEPTH-1:0]     older_r   [DEPTH];  // older_r[i][j]: i allocated before j
  logic [OCC_W-1:0]     occ_r;

  logic [DEPTH-1:0] ready_s;
  logic [IDX_W-1:0] sel_s;
  logic [IDX_W-1:0] alloc_s;
  logic             sel_hit_s;
  logic             alloc_hit_s;
  logic             blocked_s;
  logic             take_s;
  logic             disp_fire_s;
  logic             iss_fire_s;
  logic [XLEN:0]    byp_j_s;
  logic [XLEN:0]    byp_k_s;
  logic [XLEN:0]    wake_j_s [DEPTH];
  logic [XLEN:0]    wake_k_s [DEPTH];

  // Returns {hit, data}; scanning downwards lets the lowest port index win.
  function automatic logic [XLEN:0] wb_lookup(
    input logic [TAG_W-1:0]      tag,
    input logic [NWB-1:0]        v,
    input logic [NWB*TAG_W-1:0]  t,
    input logic [NWB*XLEN-1:0]   d
  );
    logic [XLEN:0] r;
    r = '0;
    for (int p = NWB - 1; p >= 0; p--) begin
      r = (v[p] && (tag != '0) && (t[p*TAG_W +: TAG_W] == tag)) ? {1'b1, d[p*XLEN +: XLEN]} : r;
    end
    return r;
  endfunction

  // Readiness, oldest-ready select and lowest-free allocation.
  always_comb begin
    sel_s       = '0;
    alloc_s     = '0;
    sel_hit_s   = 1'b0;
    alloc_hit_s = 1'b0;
    blocked_s   = 1'b0;
    take_s      = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ready_s[i] = busy_r[i] && (qj_r[i] == '0) && (qk_r[i] == '0);
    end
    for (int i = 0; i < DEPTH; i++) begin
      blocked_s = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        blocked_s = blocked_s | (ready_s[j] & older_r[j][i]);
      end
      take_s    = ~sel_hit_s & ready_s[i] & ~blocked_s;
      sel_s     = take_s ? IDX_W'(i) : sel_s;
      sel_hit_s = sel_hit_s | take_s;
      take_s      = ~alloc_hit_s & ~busy_r[i];
      alloc_s     = take_s ? IDX_W'(i) : alloc_s;
      alloc_hit_s = alloc_hit_s | take_s;
    end
  end

  // Wakeup and dispatch-bypass matches against the writeback ports.
  always_comb begin
    byp_j_s = wb_lookup(disp_qj, wb_valid, wb_tag, wb_data);
    byp_k_s = wb_lookup(disp_qk, wb_valid, wb_tag, wb_data);
    for (int i = 0; i < DEPTH; i++) begin
      wake_j_s[i] = wb_lookup(qj_r[i], wb_valid, wb_tag, wb_data);
      wake_k_s[i] = wb_lookup(qk_r[i], wb_valid, wb_tag, wb_data);
    end
  end

  assign disp_ready  = (occ_r < OCC_W'(DEPTH));
  assign disp_fire_s = disp_valid & disp_ready;
  assign iss_fire_s  = sel_hit_s & iss_ready;

  assign iss_valid   = sel_hit_s;
  assign iss_idx     = sel_s;
  assign iss_vj      = sel_hit_s ? vj_r[sel_s]      : '0;
  assign iss_vk      = sel_hit_s ? vk_r[sel_s]      : '0;
  assign iss_dest    = sel_hit_s ? dest_r[sel_s]    : '0;
  assign iss_payload = sel_hit_s ? payload_r[sel_s] : '0;
  assign occupancy   = occ_r;

  // Entry state, age matrix and occupancy update.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      busy_r <= '0;
      occ_r  <= '0;
      for (int i = 0; i < DEPTH; i++) older_r[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy_r[i] && wake_j_s[i][XLEN]) begin
          qj_r[i] <= '0;
          vj_r[i] <= wake_j_s[i][XLEN-1:0];
        end
        if (busy_r[i] && wake_k_s[i][XLEN]) begin
          qk_r[i] <= '0;
          vk_r[i] <= wake_k_s[i][XLEN-1:0];
        end
      end
      if (iss_fire_s) busy_r[sel_s] <= 1'b0;
      if (disp_fire_s) begin
        busy_r[alloc_s]    <= 1'b1;
        qj_r[alloc_s]      <= byp_j_s[XLEN] ? '0 : disp_qj;
        vj_r[alloc_s]      <= byp_j_s[XLEN] ? byp_j_s[XLEN-1:0] : disp_vj;
        qk_r[alloc_s]      <= byp_k_s[XLEN] ? '0 : disp_qk;
        vk_r[alloc_s]      <= byp_k_s[XLEN] ? byp_k_s[XLEN-1:0] : disp_vk;
        dest_r[alloc_s]    <= disp_dest;
        payload_r[alloc_s] <= disp_payload;
        older_r[alloc_s]   <= '0;
        // The issuing entry leaves this cycle, so it is not marked older.
        for (int b = 0; b < DEPTH; b++) begin
          older_r[b][alloc_s] <= busy_r[b] && !(iss_fire_s && (sel_s == IDX_W'(b)));
        end
      end
      case ({disp_fire_s, iss_fire_s})
        2'b10:   occ_r <= occ_r + OCC_W'(1);
        2'b01:   occ_r <= occ_r - OCC_W'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_rs_age.sv
// Random and directed stimulus against an age-ordered queue model of the RS.
module tb_ysyx_rs_age;
  localparam int DEPTH = 4;
  localparam int NWB   = 2;
  localparam int XLEN  = 32;
  localparam int TW    = 5;
  localparam int PW    = 64;

  logic clk;
  logic reset, flush, disp_valid, disp_ready, iss_valid, iss_ready;
  logic [TW-1:0]       disp_qj, disp_qk, disp_dest, iss_dest;
  logic [XLEN-1:0]     disp_vj, disp_vk, iss_vj, iss_vk;
  logic [PW-1:0]       disp_payload, iss_payload;
  logic [NWB-1:0]      wb_valid;
  logic [NWB*TW-1:0]   wb_tag;
  logic [NWB*XLEN-1:0] wb_data;
  logic [1:0]          iss_idx;
  logic [2:0]          occupancy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int            slot;
    logic [TW-1:0] qj, qk, dest;
    logic [XLEN-1:0] vj, vk;
    logic [PW-1:0] pl;
  } ent_t;
  ent_t q[$];  // oldest first

  ysyx_rs_age #(.DEPTH(DEPTH), .NWB(NWB), .XLEN(XLEN), .TAG_W(TW), .PAYLOAD_W(PW)) dut (
    .clock(clk), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_qj(disp_qj), .disp_qk(disp_qk), .disp_vj(disp_vj), .disp_vk(disp_vk),
    .disp_dest(disp_dest), .disp_payload(disp_payload),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_vj(iss_vj), .iss_vk(iss_vk), .iss_dest(iss_dest),
    .iss_payload(iss_payload), .iss_idx(iss_idx), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int find_ready();
    for (int i = 0; i < q.size(); i++)
      if (q[i].qj == 0 && q[i].qk == 0) return i;
    return -1;
  endfunction

  function automatic bit wb_find(input logic [TW-1:0] t, output logic [XLEN-1:0] d);
    d = '0;
    if (t == 0) return 1'b0;
    for (int p = 0; p < NWB; p++)
      if (wb_valid[p] && wb_tag[p*TW +: TW] == t) begin
        d = wb_data[p*XLEN +: XLEN];
        return 1'b1;
      end
    return 1'b0;
  endfunction

  task automatic compare();
    int si;
    si = find_ready();
    check_eq("disp_ready", 64'(disp_ready), 64'(q.size() < DEPTH));
    check_eq("occupancy",  64'(occupancy),  64'(q.size()));
    check_eq("iss_valid",  64'(iss_valid),  64'(si >= 0));
    check_eq("iss_idx",    64'(iss_idx),    (si >= 0) ? 64'(q[si].slot) : 64'd0);
    check_eq("iss_dest",   64'(iss_dest),   (si >= 0) ? 64'(q[si].dest) : 64'd0);
    check_eq("iss_vj",     64'(iss_vj),     (si >= 0) ? 64'(q[si].vj)   : 64'd0);
    check_eq("iss_vk",     64'(iss_vk),     (si >= 0) ? 64'(q[si].vk)   : 64'd0);
    check_eq("iss_payload", iss_payload,    (si >= 0) ? q[si].pl        : 64'd0);
  endtask

  task automatic model_step();
    int si;
    bit isf, dsf;
    bit used [DEPTH];
    ent_t ne;
    logic [XLEN-1:0] d;
    if (reset || flush) begin
      q.delete();
      return;
    end
    si  = find_ready();
    isf = (si >= 0) && iss_ready;
    dsf = disp_valid && (q.size() < DEPTH);
    for (int s = 0; s < DEPTH; s++) used[s] = 1'b0;
    foreach (q[i]) used[q[i].slot] = 1'b1;
    ne.slot = DEPTH;
    for (int s = DEPTH - 1; s >= 0; s--) if (!used[s]) ne.slot = s;
    ne.qj = disp_qj; ne.vj = disp_vj; ne.qk = disp_qk; ne.vk = disp_vk;
    ne.dest = disp_dest; ne.pl = disp_payload;
    if (wb_find(disp_qj, d)) begin ne.qj = '0; ne.vj = d; end
    if (wb_find(disp_qk, d)) begin ne.qk = '0; ne.vk = d; end
    for (int i = 0; i < q.size(); i++) begin
      ent_t e = q[i];
      if (wb_find(e.qj, d)) begin e.qj = '0; e.vj = d; end
      if (wb_find(e.qk, d)) begin e.qk = '0; e.vk = d; end
      q[i] = e;
    end
    if (isf) q.delete(si);
    if (dsf) q.push_back(ne);
  endtask

  // Inputs are already driven (just after posedge); check at negedge, then advance.
  task automatic tick();
    @(negedge clk);
    compare();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; flush = 1'b0; disp_valid = 1'b0; iss_ready = 1'b0;
    disp_qj = '0; disp_qk = '0; disp_dest = '0;
    disp_vj = $urandom; disp_vk = $urandom; disp_payload = {$urandom, $urandom};
    wb_valid = '0; wb_tag = '0; wb_data = '0;
  endtask

  task automatic disp(input logic [TW-1:0] qj, input logic [TW-1:0] qk,
                      input logic [TW-1:0] dest, input logic ir);
    idle();
    disp_valid = 1'b1; disp_qj = qj; disp_qk = qk; disp_dest = dest; iss_ready = ir;
  endtask

  initial begin
    int pd, pi, pw;
    idle();
    reset = 1'b1;
    @(posedge clk); #1;
    tick();  // reset still held: reset state is checked here

    // Age order: three ready entries held, then drained oldest first.
    disp(5'd0, 5'd0, 5'd1, 1'b0); tick();
    disp(5'd0, 5'd0, 5'd2, 1'b0); tick();
    disp(5'd0, 5'd0, 5'd3, 1'b0); tick();
    idle(); repeat (3) tick();
    idle(); iss_ready = 1'b1; repeat (4) tick();

    // Wakeup of an older waiting entry.
    disp(5'd9, 5'd0, 5'd5, 1'b0); tick();
    disp(5'd0, 5'd0, 5'd6, 1'b1); tick();
    idle(); iss_ready = 1'b1; tick();
    idle(); wb_valid = 2'b10; wb_tag = {5'd9, 5'd0}; wb_data = {32'hDEAD, 32'h0}; tick();
    idle(); iss_ready = 1'b1; repeat (2) tick();

    // Dispatch bypass on operand k, with both ports hitting the same tag.
    disp(5'd0, 5'd7, 5'd4, 1'b0);
    wb_valid = 2'b11; wb_tag = {5'd7, 5'd7}; wb_data = {32'h5555, 32'h1234}; tick();
    idle(); iss_ready = 1'b1; repeat (2) tick();

    // Full, ignored dispatch, then dispatch plus issue together.
    for (int i = 0; i < 5; i++) begin disp(5'd0, 5'd0, 5'(10 + i), 1'b0); tick(); end
    idle(); iss_ready = 1'b1; tick();
    disp(5'd0, 5'd0, 5'd20, 1'b1); tick();
    idle(); iss_ready = 1'b1; repeat (5) tick();

    // Flush with three busy entries and live handshakes.
    for (int i = 0; i < 3; i++) begin disp(5'd0, 5'd0, 5'(i + 1), 1'b0); tick(); end
    disp(5'd0, 5'd0, 5'd8, 1'b1); flush = 1'b1; tick();
    idle(); tick();

    // Reset after filling three entries.
    for (int i = 0; i < 3; i++) begin disp(5'(i + 2), 5'd0, 5'(i + 1), 1'b0); tick(); end
    idle(); tick(); reset = 1'b1; tick();
    idle(); tick();

    // Randomized phases with varying dispatch/issue/wakeup pressure.
    for (int ph = 0; ph < 3; ph++) begin
      pd = (ph == 0) ? 80 : (ph == 1) ? 50 : 30;
      pi = (ph == 0) ? 30 : (ph == 1) ? 50 : 90;
      pw = (ph == 2) ? 60 : 30;
      for (int n = 0; n < 1500; n++) begin
        idle();
        disp_valid = ($urandom_range(99, 0) < pd);
        iss_ready  = ($urandom_range(99, 0) < pi);
        disp_qj    = ($urandom_range(2, 0) == 0) ? 5'($urandom_range(7, 0)) : 5'd0;
        disp_qk    = ($urandom_range(2, 0) == 0) ? 5'($urandom_range(7, 0)) : 5'd0;
        disp_dest  = 5'($urandom_range(31, 0));
        for (int p = 0; p < NWB; p++) begin
          wb_valid[p]           = ($urandom_range(99, 0) < pw);
          wb_tag[p*TW +: TW]    = 5'($urandom_range(7, 0));
          wb_data[p*XLEN +: XLEN] = $urandom;
        end
        flush = ($urandom_range(199, 0) == 0);
        reset = ($urandom_range(299, 0) == 0);
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
